systolic_operand_feeder: RTL and testbench

Upstream stage of the 5x5 systolic array. It buffers operand matrices A (NxN) and B (NxN), then streams them into the array's west and north edges with the diagonal skew the PEs require. It issues the one-cycle `ctrl_init` pulse that starts the systolic array controller's read/write/clr schedule, aligned with the first feed beat. It signals completion to the host.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/operand_bank.sv | 36 +++
 rtl/systolic_operand_feeder.sv | 127 ++++++++++++
 tb/tb_systolic_operand_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: array geometry,
// operand width, feeder FSM states and the length of one skewed feed.
package systolic_pkg;
    localparam int N          = 5;
    localparam int DW         = 8;
    localparam int AW         = $clog2(N*N);
    localparam int SW         = $clog2(3*N-1);
    localparam int FEED_STEPS = 3*N-2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/operand_bank.sv
// NxN operand register file: one write port, N skewed read lanes for a given
// feed step. COL_LANE=0 reads A by row lane, COL_LANE=1 reads B by column lane.
module operand_bank
    import systolic_pkg::*;
#(
    parameter bit COL_LANE = 1'b0
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [SW-1:0]   step,
    output logic [N*DW-1:0] rd
);
    logic [DW-1:0] mem [N*N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A write landing on the same edge as the step-0 read is forwarded so the
    // first beat already sees it.
    always_comb begin
        rd = '0;
        for (int l = 0; l < N; l++) begin
            logic signed [SW:0] off;
            logic [AW-1:0]      idx;
            off = $signed({1'b0, step}) - $signed((SW+1)'(l));
            idx = '0;
            if (!off[SW] && (off < $signed((SW+1)'(N)))) begin
                idx = COL_LANE ? AW'(int'(off) * N + l) : AW'(l * N + int'(off));
                rd[l*DW +: DW] = (we && (waddr == idx)) ? wdata : mem[idx];
            end
        end
    end
endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers operand matrices A and B and streams them, diagonally skewed, into
// the west/north edges of the systolic array, with ctrl_init on the first beat.
//
// state | meaning
// IDLE  | buffers writable, waiting for start
// FEED  | streaming skewed beats, step 0 .. FEED_STEPS-1
// DONE  | single cycle, done pulse, then back to IDLE
module systolic_operand_feeder
    import systolic_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_err,
    input  logic            start,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            feed_valid,
    output logic            ctrl_init,
    output logic            busy,
    output logic            done
);
    feeder_state_t   state, state_nx;
    logic [SW-1:0]   step, step_nx, rd_step;
    logic [N*DW-1:0] a_rd, b_rd, a_nx, b_nx;
    logic            fv_nx, ci_nx, busy_nx, done_nx;
    logic            wr_ok, wr_bad, last_step;

    assign last_step = (step == SW'(FEED_STEPS - 1));
    assign wr_ok     = wr_en && (state == IDLE) && (32'(wr_addr) < 32'(N*N));
    assign wr_bad    = wr_en && !wr_ok;
    // Outputs are registered, so the banks are read for the step about to be shown.
    assign rd_step   = (state == FEED) ? step + SW'(1) : '0;

    operand_bank #(.COL_LANE(1'b0)) u_bank_a (
        .clk   (clk),
        .we    (wr_ok && !wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .step  (rd_step),
        .rd    (a_rd)
    );

    operand_bank #(.COL_LANE(1'b1)) u_bank_b (
        .clk   (clk),
        .we    (wr_ok && wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .step  (rd_step),
        .rd    (b_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FEED;
            FEED:    if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        step_nx = step;
        a_nx    = '0;
        b_nx    = '0;
        fv_nx   = 1'b0;
        ci_nx   = 1'b0;
        busy_nx = 1'b0;
        done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    step_nx = '0;
                    a_nx    = a_rd;
                    b_nx    = b_rd;
                    fv_nx   = 1'b1;
                    ci_nx   = 1'b1;
                    busy_nx = 1'b1;
                end
            end
            FEED: begin
                busy_nx = 1'b1;
                if (last_step) begin
                    step_nx = '0;
                    done_nx = 1'b1;
                end else begin
                    step_nx = step + SW'(1);
                    a_nx    = a_rd;
                    b_nx    = b_rd;
                    fv_nx   = 1'b1;
                end
            end
            default: step_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step       <= '0;
            a_out      <= '0;
            b_out      <= '0;
            feed_valid <= 1'b0;
            ctrl_init  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            step       <= step_nx;
            a_out      <= a_nx;
            b_out      <= b_nx;
            feed_valid <= fv_nx;
            ctrl_init  <= ci_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            wr_err     <= wr_bad;
        end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed self-checking bench for systolic_operand_feeder.
module tb_systolic_operand_feeder;
    import systolic_pkg::*;

    localparam int BEATS = 3*N-2;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_err;
    logic            start;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            feed_valid;
    logic            ctrl_init;
    logic            busy;
    logic            done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] ea [N*N];
    logic [DW-1:0] eb [N*N];

    systolic_operand_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .feed_valid (feed_valid),
        .ctrl_init  (ctrl_init),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ea[i*N + (t - i)];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = eb[(t - j)*N + j];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input logic sel, input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_feed();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks the BEATS feed cycles after start was sampled; optionally injects a
    // rejected write at beat wr_at and an ignored start at beat st_at.
    // Ends on the done cycle.
    task automatic check_beats(input string tag, input int wr_at, input int st_at);
        for (int t = 0; t < BEATS; t++) begin
            n_chk++;
            if (feed_valid !== 1'b1 || ctrl_init !== (t == 0) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s beat%0d ctrl: fv=%b ci=%b busy=%b done=%b, required fv=1 ci=%b busy=1 done=0",
                         tag, t, feed_valid, ctrl_init, busy, done, (t == 0));
            end
            n_chk++;
            if (a_out !== exp_a(t) || b_out !== exp_b(t)) begin
                n_fail++;
                $display("FAIL %s beat%0d data: a=%h b=%h, required a=%h b=%h",
                         tag, t, a_out, b_out, exp_a(t), exp_b(t));
            end
            if (wr_at >= 0 && t == wr_at + 1) begin
                n_chk++;
                if (wr_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_wr_err: got %b, required 1", tag, wr_err);
                end
            end
            if (t == wr_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'hFF;
            end
            if (t == st_at) start = 1'b1;
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end
        n_chk++;
        if (done !== 1'b1 || feed_valid !== 1'b0 || busy !== 1'b1 || a_out !== '0 || b_out !== '0) begin
            n_fail++;
            $display("FAIL %s done_cycle: done=%b fv=%b busy=%b a=%h b=%h, required done=1 fv=0 busy=1 a=0 b=0",
                     tag, done, feed_valid, busy, a_out, b_out);
        end
    endtask

    task automatic check_idle(input string tag);
        tick();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || feed_valid !== 1'b0 || ctrl_init !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: done=%b busy=%b fv=%b ci=%b, required all 0",
                     tag, done, busy, feed_valid, ctrl_init);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            wr_en   = 1'($urandom);
            wr_sel  = 1'($urandom);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            start   = 1'($urandom);
            tick();
            n_chk++;
            if (a_out !== '0 || b_out !== '0 || feed_valid !== 1'b0 || ctrl_init !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: a=%h b=%h fv=%b ci=%b busy=%b done=%b err=%b, required all 0",
                         a_out, b_out, feed_valid, ctrl_init, busy, done, wr_err);
            end
        end
        wr_en = 1'b0; start = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        rst_n = 1'b1;
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b0 || feed_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b fv=%b done=%b, required 0 0 0", busy, feed_valid, done);
        end
    endtask

    task automatic load_buffers();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ea[r*N+c] = DW'(10*r + c + 1);
                eb[r*N+c] = DW'(100 + 10*r + c);
                write_op(1'b0, r*N+c, ea[r*N+c]);
                write_op(1'b1, r*N+c, eb[r*N+c]);
            end
        n_chk++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wr_err: got %b, required 0", wr_err);
        end
    endtask

    task automatic test_skew();
        start_feed();
        for (int t = 0; t < BEATS; t++) begin
            if (t == 2) begin
                n_chk++;
                if (a_out !== {8'd0, 8'd0, 8'd21, 8'd12, 8'd3} ||
                    b_out !== {8'd0, 8'd0, 8'd102, 8'd111, 8'd120}) begin
                    n_fail++;
                    $display("FAIL skew_step2: a=%h b=%h, required a=0000150c03 b=0000666f78", a_out, b_out);
                end
            end
            if (t == 8) begin
                n_chk++;
                if (a_out !== {8'd45, 32'd0} || b_out !== {8'd144, 32'd0}) begin
                    n_fail++;
                    $display("FAIL skew_step8: a=%h b=%h, required a=2d00000000 b=9000000000", a_out, b_out);
                end
            end
            if (t == 12) begin
                n_chk++;
                if (a_out !== '0 || b_out !== '0 || feed_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL skew_step12: a=%h b=%h fv=%b, required 0 0 1", a_out, b_out, feed_valid);
                end
            end
            if (t < BEATS - 1) tick();
        end
        tick();
        n_chk++;
        if (done !== 1'b1 || feed_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_end: done=%b fv=%b, required 1 0", done, feed_valid);
        end
        check_idle("skew");
        start_feed();
        check_beats("skew_model", -1, -1);
        check_idle("skew_model");
    endtask

    task automatic test_busy_reject();
        start_feed();
        check_beats("busy", 3, 5);
        start = 1'b1;
        check_idle("busy_start_in_done");
        start = 1'b0;
        n_chk++;
        if (feed_valid !== 1'b0 || ctrl_init !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: fv=%b ci=%b, required 0 0", feed_valid, ctrl_init);
        end
        start_feed();
        n_chk++;
        if (a_out[DW-1:0] !== 8'd1) begin
            n_fail++;
            $display("FAIL busy_a00_kept: got %0d, required 1", a_out[DW-1:0]);
        end
        check_beats("busy_after", -1, -1);
        check_idle("busy_after");
    endtask

    task automatic test_bad_addr();
        write_op(1'b0, 25, 8'hEE);
        n_chk++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_addr_a: wr_err=%b, required 1", wr_err);
        end
        write_op(1'b1, 31, 8'hEE);
        n_chk++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_addr_b: wr_err=%b, required 1", wr_err);
        end
        write_op(1'b0, 24, ea[24]);
        n_chk++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_addr24: wr_err=%b, required 0", wr_err);
        end
        start_feed();
        check_beats("bad_addr", -1, -1);
        check_idle("bad_addr");
    endtask

    task automatic test_write_with_start();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'h77;
        start = 1'b1;
        ea[0] = 8'h77;
        tick();
        wr_en = 1'b0; start = 1'b0;
        n_chk++;
        if (a_out[DW-1:0] !== 8'h77 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_with_start: a0=%h err=%b, required 77 0", a_out[DW-1:0], wr_err);
        end
        check_beats("wr_start", -1, -1);
        check_idle("wr_start");
        ea[0] = 8'd1;
        write_op(1'b0, 0, 8'd1);
    endtask

    task automatic test_reset_mid();
        start_feed();
        for (int t = 0; t < 6; t++) tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (a_out !== '0 || b_out !== '0 || feed_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: a=%h b=%h fv=%b busy=%b done=%b, required all 0",
                     a_out, b_out, feed_valid, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (done !== 1'b0 || feed_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_no_done: done=%b fv=%b, required 0 0", done, feed_valid);
            end
        end
        rst_n = 1'b1;
        tick();
        start_feed();
        check_beats("after_midreset", -1, -1);
        check_idle("after_midreset");
    endtask

    task automatic test_back_to_back();
        start_feed();
        check_beats("b2b_first", -1, -1);
        check_idle("b2b_gap");
        start_feed();
        check_beats("b2b_second", -1, -1);
        check_idle("b2b_second");
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        test_reset();
        load_buffers();
        test_skew();
        test_busy_reject();
        test_bad_addr();
        test_write_with_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
